// File: rtl/debouncer.sv
// rtl/debouncer.sv - two-flop synchroniser plus stability counter for a bouncy button input
// out follows the synchronised level only after STABLE_CYCLES consecutive differing cycles.
module debouncer #(
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic signal,
    output logic out
);

    localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 r_s1;
    logic                 r_s2;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_differs;
    logic                 w_cnt_done;

    assign w_differs  = (r_s2 != out);
    assign w_cnt_done = (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= signal;
            r_s2 <= r_s1;
        end
    end

    // Any cycle where s2 matches out clears the count, so glitches never accumulate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            out   <= 1'b0;
        end else if (!w_differs) begin
            r_cnt <= '0;
        end else if (w_cnt_done) begin
            out   <= r_s2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_debouncer.sv
// tb/tb_debouncer.sv - self-checking bench for debouncer (STABLE_CYCLES 4 and 1)
// Model keeps a history of synchronised samples and flips out after N consecutive differing ones.
module tb_debouncer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sig   = 1'b0;
    logic out4;
    logic out1;

    int checks = 0;
    int errors = 0;

    debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .signal (sig),
        .out    (out4)
    );

    debouncer #(.STABLE_CYCLES(1), .CNT_WIDTH(3)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .signal (sig),
        .out    (out1)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: history of pre-edge s2 samples, newest in bit 0.
    int         nstab [2] = '{4, 1};
    bit         m_s1, m_s2;
    bit         m_out [2];
    int         m_cnt [2];
    logic [31:0] m_hist;
    int         m_len;
    bit         m_valid = 1'b0;

    function automatic int trailing(input logic [31:0] h, input int len, input bit o);
        int t = 0;
        while (t < len && t < 32 && h[t] != o) t++;
        return t;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            m_hist  = '0;
            m_len   = 0;
            m_valid = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_out[k] = 1'b0;
                m_cnt[k] = 0;
            end
        end else begin
            m_hist = {m_hist[30:0], m_s2};
            m_len  = (m_len < 32) ? m_len + 1 : 32;
            for (int k = 0; k < 2; k++) begin
                int t;
                t = trailing(m_hist, m_len, m_out[k]);
                if (t >= nstab[k]) begin
                    m_out[k] = m_s2;
                    m_cnt[k] = 0;
                end else begin
                    m_cnt[k] = t;
                end
            end
            m_s2 = m_s1;
            m_s1 = sig;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_out_n4", {31'b0, out4}, {31'b0, m_out[0]});
            chk("model_out_n1", {31'b0, out1}, {31'b0, m_out[1]});
            chk("model_cnt_n4", {29'b0, dut.r_cnt}, 32'(m_cnt[0]));
            chk("model_cnt_n1", {29'b0, dut1.r_cnt}, 32'(m_cnt[1]));
        end
    end

    initial begin
        int  peak;
        bit  v;
        bit  old;

        // Reset held with signal high; out clears asynchronously before any clock edge.
        #2 reset = 1'b0;
        sig = 1'b1;
        #1 chk("async_reset_initial", {31'b0, out4}, 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("held_reset_out", {31'b0, out4}, 32'd0);
        end

        // Release: first edge after release is edge 0; out rises at edge 5 (N=4), edge 2 (N=1).
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("release_rise_n4", {31'b0, out4}, (i >= 5) ? 32'd1 : 32'd0);
            chk("release_rise_n1", {31'b0, out1}, (i >= 2) ? 32'd1 : 32'd0);
        end

        // Three-edge low glitches: count peaks at 3 but never completes.
        peak = 0;
        repeat (5) begin
            sig = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (int'(dut.r_cnt) > peak) peak = int'(dut.r_cnt);
                chk("glitch_hold_out", {31'b0, out4}, 32'd1);
            end
            sig = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (int'(dut.r_cnt) > peak) peak = int'(dut.r_cnt);
                chk("glitch_hold_out", {31'b0, out4}, 32'd1);
            end
        end
        chk("glitch_cnt_peak", 32'(peak), 32'd3);

        // Bounce every edge, then steady low: falls 5 edges after the first steady capture.
        for (int i = 0; i < 10; i++) begin
            sig = (i % 2 == 1);
            @(negedge clk);
            chk("bounce_hold_out", {31'b0, out4}, 32'd1);
        end
        sig = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bounce_fall", {31'b0, out4}, (i >= 5) ? 32'd0 : 32'd1);
        end

        // Reset mid-count after two increments; counting restarts from zero.
        sig = 1'b1;
        repeat (4) @(negedge clk);
        chk("midcount_cnt", {29'b0, dut.r_cnt}, 32'd2);
        #3 reset = 1'b0;
        #1 chk("midcount_reset_out", {31'b0, out4}, 32'd0);
        chk("midcount_reset_cnt", {29'b0, dut.r_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("restart_rise", {31'b0, out4}, (i >= 5) ? 32'd1 : 32'd0);
        end

        // Asynchronous clear while out is high.
        #3 reset = 1'b0;
        #1 chk("async_clear_n4", {31'b0, out4}, 32'd0);
        chk("async_clear_n1", {31'b0, out1}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // N=1: toggle every 4 edges; out follows 2 edges after the capturing edge.
        v = 1'b1;
        for (int r = 0; r < 6; r++) begin
            old = v;
            v   = ~v;
            sig = v;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("follow_n1", {31'b0, out1}, {31'b0, (i >= 2) ? v : old});
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
